// File: rtl/div_pkg.sv
// Shared types for the divider rounding controller.
// Holds the rounding-mode and FSM state enums plus the remainder sign-class struct.
// Used by: div_round_ctrl, rem_classify.
package div_pkg;

    typedef enum logic {
        RM_NE = 1'b0,
        RM_Z  = 1'b1
    } round_mode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RND  = 3'd3,
        OUT  = 3'd4
    } div_round_state_t;

    typedef struct packed {
        logic pos;
        logic zero;
        logic neg;
    } rem_class_t;

endpackage

// File: rtl/div_round_ctrl_rem_classify.sv
// Purpose: exact remainder r = n_ext - p and its positive/zero/negative class.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: n_ext, mul_p (2*WIDTH unsigned) in; rcls (rem_class_t) out.
module rem_classify
    import div_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic [2*WIDTH-1:0] n_ext,
    input  logic [2*WIDTH-1:0] mul_p,
    output rem_class_t         rcls
);

    // One extra bit so an unsigned underflow shows up as a set sign bit.
    logic [2*WIDTH:0] rem;

    assign rem       = {1'b0, n_ext} - {1'b0, mul_p};
    assign rcls.neg  = rem[2*WIDTH];
    assign rcls.zero = (rem == '0);
    assign rcls.pos  = !rem[2*WIDTH] && (rem != '0);

endmodule

// File: rtl/div_round_ctrl.sv
// Purpose: final RNE/RZ rounding of a guard-extended divider quotient, using a shared multiplier
//          to form the exact remainder n_ext - q*d.
// Latency: start to y_valid = 3 + grant wait + multiplier latency (4 minimum).
// Backpressure: mul_req held until mul_gnt; y/y_valid held until y_ready; start ignored unless IDLE.
// Ports: clk/reset (sync, active-high); start, rm, q, d, n_ext launch inputs; busy;
//        mul_req/mul_gnt/mul_a/mul_b/mul_valid/mul_p multiplier handshake; y/y_valid/y_ready result.
// Optional: `define DIV_ROUND_INEXACT_EN adds the inexact output, valid with y_valid.
module div_round_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int ULP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rm,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     d,
    input  logic [2*WIDTH-1:0]   n_ext,
    output logic                 busy,
    output logic                 mul_req,
    input  logic                 mul_gnt,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_valid,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
`ifdef DIV_ROUND_INEXACT_EN
    output logic                 inexact,
`endif
    input  logic                 y_ready
);

    div_round_state_t state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [2*WIDTH-1:0] n_q, n_d;
    round_mode_t        rm_q, rm_d;
    rem_class_t         rcls_q, rcls_d;
    logic               busy_q, busy_d;
    logic               mul_req_q, mul_req_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               inexact_q, inexact_d;

    rem_class_t         rcls_w;

    rem_classify #(.WIDTH(WIDTH)) u_rem_classify (
        .n_ext (n_q),
        .mul_p (mul_p),
        .rcls  (rcls_w)
    );

    // Rounding datapath on the latched quotient and registered remainder class.
    logic [WIDTH-1:0] t_w, u_w, y_rnd_w;
    logic             g_w, s_w, guard_nz_w, rne_up_w, rz_dn_w;

    assign t_w        = {q_q[WIDTH-1:ULP], {ULP{1'b0}}};
    assign u_w        = WIDTH'(1) << ULP;
    assign g_w        = q_q[ULP-1];
    assign s_w        = |q_q[ULP-2:0];
    assign guard_nz_w = |q_q[ULP-1:0];
    // Ties (g set, nothing below it, remainder exactly zero) go to the even result.
    assign rne_up_w   = g_w && (s_w || rcls_q.pos || (rcls_q.zero && t_w[ULP]));
    // A negative remainder with clear guard bits means the estimate overshot by one ULP.
    assign rz_dn_w    = rcls_q.neg && !guard_nz_w;
    assign y_rnd_w    = (rm_q == RM_NE) ? (rne_up_w ? t_w + u_w : t_w)
                                        : (rz_dn_w  ? t_w - u_w : t_w);

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        d_d       = d_q;
        n_d       = n_q;
        rm_d      = rm_q;
        rcls_d    = rcls_q;
        mul_req_d = mul_req_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        inexact_d = inexact_q;
        unique case (state_q)
            IDLE: if (start) begin
                q_d       = q;
                d_d       = d;
                n_d       = n_ext;
                rm_d      = round_mode_t'(rm);
                mul_req_d = 1'b1;
                state_d   = REQ;
            end
            REQ: if (mul_gnt) begin
                mul_req_d = 1'b0;
                state_d   = WAIT;
            end
            WAIT: if (mul_valid) begin
                rcls_d  = rcls_w;
                state_d = RND;
            end
            RND: begin
                y_d       = y_rnd_w;
                y_valid_d = 1'b1;
                inexact_d = !rcls_q.zero || guard_nz_w;
                state_d   = OUT;
            end
            OUT: if (y_ready) begin
                y_valid_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            rm_q      <= RM_NE;
            rcls_q    <= '0;
            busy_q    <= 1'b0;
            mul_req_q <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            d_q       <= d_d;
            n_q       <= n_d;
            rm_q      <= rm_d;
            rcls_q    <= rcls_d;
            busy_q    <= busy_d;
            mul_req_q <= mul_req_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            inexact_q <= inexact_d;
        end
    end

    // The request is withdrawn as soon as reset is seen, not one edge later.
    assign mul_req = mul_req_q && !reset;
    assign mul_a   = q_q;
    assign mul_b   = d_q;
    assign busy    = busy_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
`ifdef DIV_ROUND_INEXACT_EN
    assign inexact = inexact_q;
`endif

endmodule
